updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter and successor to the 4-bit direction-controlled counter.
- Adds configurable width, runtime terminal value (limit), parallel load, count enable, and wrap-or-saturate mode.
- Adds a registered terminal-count pulse and boundary flags.
- Used as the general counter/timer primitive in lab designs: LED sequencers, clock dividers, event counters.

Parameters:
WIDTH, 4, counter bit width (legal range 2..32).
RST_VAL, 0, count value loaded on reset; must be <= 2^WIDTH-1.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous reset, active-low.
en  input  1  count enable; one step per clk edge while high.
dir  input  1  direction: 0 = up, 1 = down.
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  value to load.
limit  input  WIDTH  terminal value; counter range is 0..limit.
sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
count  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle wide.
at_max  output  1  combinational: count == limit.
at_zero  output  1  combinational: count == 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - count = RST_VAL and tc = 0 immediately, independent of clk.
  - Reset asserted mid-count aborts the step in progress.
  - After deassertion, the first step occurs on the first rising edge with en or load high.
- Priority per rising edge: load > en > hold.
- Load:
  - count <= min(load_val, limit).
  - tc <= 0. dir and sat are ignored.
- Hold (en = 0, load = 0): count unchanged, tc <= 0.
- Up step (en = 1, dir = 0):
  - count < limit: count <= count + 1, tc <= 0.
  - count >= limit, sat = 0: count <= 0, tc <= 1.
  - count >= limit, sat = 1: count <= limit, tc <= 1.
- Down step (en = 1, dir = 1):
  - count == 0, sat = 0: count <= limit, tc <= 1.
  - count == 0, sat = 1: count <= 0, tc <= 1.
  - count > limit (limit lowered at runtime): count <= limit, tc <= 0.
  - Otherwise: count <= count - 1, tc <= 0.
- tc:
  - Asserted for exactly the one cycle following a boundary step.
  - Stays high on consecutive cycles if consecutive steps hit the boundary, e.g. while saturated with en held.
- dir, sat and limit are sampled on the same edge as the step. A dir change takes effect on that edge, with no dead cycle.
- limit = 0: count holds at 0 and every enabled step asserts tc in both modes.
- limit = 2^WIDTH-1: full natural-range wrap.
- All arithmetic is unsigned WIDTH-bit. No intermediate overflow is visible on count.
- at_max and at_zero are decoded from the registered count and the current limit. Both may be high together when limit = 0.
- No latches. All state lives in count and tc.

Test Plan:
1. WIDTH=4, limit=15, sat=0, dir=0, en=1 from reset, 20 cycles → count 0,1,…,15,0,1,2,3. tc high only in the cycle count shows 0 after 15.
2. Same setup, dir toggled every 15 cycles (300 ns at a 20 ns clock) → count reaches 14 (after 14 steps; dir flips on the 15th edge), then steps 13,12,…. On reaching 0 it wraps to 15 with a tc pulse. No dead cycle at the dir change.
3. limit=9, sat=1, dir=0, en=1 from count 7 → 8, 9, 9, 9. tc = 0, 0, 1, 1; at_max high from count 9. Then dir=1 → 8, 7, … 0, 0 with tc on the held-0 cycles.
4. load=1 with load_val=12, limit=9 → count=9, tc=0. Then load and en both high with load_val=3, dir=0 → count=3, because load wins over en.
5. Count running at 6 (limit=15); lower limit to 4 with dir=0 → next edge count=0 (sat=0) and tc=1. Repeat with dir=1 → count=4, tc=0.
6. Assert rst low asynchronously between clock edges while count=11, tc=1 → count=RST_VAL and tc=0 before the next edge. Release rst → count resumes from RST_VAL on the first enabled edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with a runtime terminal
// value, parallel load, count enable and a wrap-or-saturate boundary mode.
// The counter range is 0..limit. tc is a registered pulse marking the cycle
// after any step that hit a boundary. at_max/at_zero are decoded flags.
//
// Control priority on each rising edge: load, then en, then hold.
// There is no handshake. count/tc are valid on every cycle outside reset.
// Each edge's decision is exposed on step_op so a checker can bind to it.
module updown_counter_param #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  // Kind of step taken on the next edge. Boundary kinds are the ones that set tc.
  typedef enum logic [3:0] {
    OP_HOLD    = 4'd0,
    OP_LOAD    = 4'd1,
    OP_INC     = 4'd2,
    OP_DEC     = 4'd3,
    OP_WRAP_UP = 4'd4,
    OP_SAT_UP  = 4'd5,
    OP_WRAP_DN = 4'd6,
    OP_SAT_DN  = 4'd7,
    OP_CLAMP   = 4'd8
  } step_op_t;

  step_op_t         step_op;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] load_clip;

  // A loaded value is clipped to the current terminal value.
  assign load_clip = (load_val > limit) ? limit : load_val;

  // Classify this edge's step from the controls and the registered count.
  always_comb begin
    step_op = OP_HOLD;
    if (load) begin
      step_op = OP_LOAD;
    end else if (en) begin
      if (!dir) begin
        // Up: count at or above limit (limit may have been lowered) is a boundary.
        if (count >= limit) begin
          step_op = sat ? OP_SAT_UP : OP_WRAP_UP;
        end else begin
          step_op = OP_INC;
        end
      end else begin
        // Down: zero is the boundary. An out-of-range count snaps to limit quietly.
        if (count == ZERO) begin
          step_op = sat ? OP_SAT_DN : OP_WRAP_DN;
        end else if (count > limit) begin
          step_op = OP_CLAMP;
        end else begin
          step_op = OP_DEC;
        end
      end
    end
  end

  // Compute the next count and terminal-count pulse from the step kind.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    case (step_op)
      OP_LOAD:    count_nxt = load_clip;
      OP_INC:     count_nxt = count + ONE;
      OP_DEC:     count_nxt = count - ONE;
      OP_CLAMP:   count_nxt = limit;
      OP_WRAP_UP: begin
        count_nxt = ZERO;
        tc_nxt    = 1'b1;
      end
      OP_SAT_UP:  begin
        count_nxt = limit;
        tc_nxt    = 1'b1;
      end
      OP_WRAP_DN: begin
        count_nxt = limit;
        tc_nxt    = 1'b1;
      end
      OP_SAT_DN:  begin
        count_nxt = ZERO;
        tc_nxt    = 1'b1;
      end
      default:    begin
        count_nxt = count;
        tc_nxt    = 1'b0;
      end
    endcase
  end

  // Count and tc registers. Reset is asynchronous and aborts any step in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_COUNT;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

  // Boundary flags follow the registered count and the live limit.
  assign at_max  = (count == limit);
  assign at_zero = (count == ZERO);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4, RST_VAL=0).
// Driver tasks apply one step per cycle on the falling edge and push the
// hand-computed response. The monitor pops and compares after each rising edge.
module tb_updown_counter_param;

  localparam int W = 4;
  localparam int EW = W + 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic         sat;
  logic [W-1:0] count;
  logic         tc;
  logic         at_max;
  logic         at_zero;

  logic [EW-1:0] exp_q[$];
  int            id_q[$];
  int            step_no;
  int            checks;
  int            failures;

  updown_counter_param #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .sat      (sat),
    .count    (count),
    .tc       (tc),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  // Clock: 20 ns period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Queue the response expected after the coming rising edge.
  task automatic push_exp(input logic [W-1:0] ec, input logic etc, input logic [W-1:0] lim);
    exp_q.push_back({ec, etc, (ec == lim), (ec == '0)});
    id_q.push_back(step_no);
    step_no++;
  endtask

  // Apply one cycle of controls and record its expected result.
  task automatic drive(input logic e, input logic d, input logic l,
                       input logic [W-1:0] lv, input logic [W-1:0] lim, input logic s,
                       input logic [W-1:0] ec, input logic etc);
    @(negedge clk);
    en = e; dir = d; load = l; load_val = lv; limit = lim; sat = s;
    push_exp(ec, etc, lim);
  endtask

  // Immediate comparison used where no edge is involved (async reset).
  task automatic check_now(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got {count,tc,at_max,at_zero}=%h expected %h", name, got, exp);
    end
  endtask

  // Monitor: one response per rising edge while expectations are pending.
  initial begin
    logic [EW-1:0] e;
    int            id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        checks++;
        if ({count, tc, at_max, at_zero} !== e) begin
          failures++;
          $display("FAIL step %0d got {count,tc,at_max,at_zero}=%h expected %h",
                   id, {count, tc, at_max, at_zero}, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired with %0d pending", exp_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Stimulus.
  initial begin
    checks = 0; failures = 0; step_no = 0;
    rst = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = '0; limit = 4'd15; sat = 1'b0;
    #1;
    check_now("reset_state", {count, tc, at_max, at_zero}, {4'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset: hold at 0.
    drive(0, 0, 0, 0, 15, 0, 0, 0);

    // Plain up count over the full range, wrap with tc at 15 -> 0.
    for (int k = 1; k <= 19; k++) drive(1, 0, 0, 0, 15, 0, 4'(k % 16), (k == 16));

    // Up to 14, reverse with no dead cycle, down to 0, wrap to 15, then up-wrap.
    drive(0, 0, 1, 0, 15, 0, 0, 0);
    for (int k = 1; k <= 14; k++) drive(1, 0, 0, 0, 15, 0, 4'(k), 0);
    for (int k = 1; k <= 14; k++) drive(1, 1, 0, 0, 15, 0, 4'(14 - k), 0);
    drive(1, 1, 0, 0, 15, 0, 15, 1);
    drive(1, 0, 0, 0, 15, 0, 0, 1);

    // Saturate at limit 9 going up, then down to a held 0.
    drive(0, 0, 1, 7, 9, 1, 7, 0);
    drive(1, 0, 0, 0, 9, 1, 8, 0);
    drive(1, 0, 0, 0, 9, 1, 9, 0);
    drive(1, 0, 0, 0, 9, 1, 9, 1);
    drive(1, 0, 0, 0, 9, 1, 9, 1);
    for (int k = 1; k <= 9; k++) drive(1, 1, 0, 0, 9, 1, 4'(9 - k), 0);
    drive(1, 1, 0, 0, 9, 1, 0, 1);
    drive(1, 1, 0, 0, 9, 1, 0, 1);

    // Load is clipped to limit and wins over en.
    drive(0, 0, 1, 12, 9, 0, 9, 0);
    drive(1, 0, 1, 3, 9, 0, 3, 0);
    drive(0, 1, 0, 0, 9, 1, 3, 0);

    // Limit lowered below the running count.
    drive(0, 0, 1, 6, 15, 0, 6, 0);
    drive(1, 0, 0, 0, 4, 0, 0, 1);
    drive(0, 0, 1, 6, 15, 0, 6, 0);
    drive(1, 1, 0, 0, 4, 0, 4, 0);

    // limit = 0: always at 0, every enabled step pulses tc.
    drive(0, 0, 1, 5, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // Reach count 11 with tc high, then reset between edges.
    drive(0, 0, 1, 10, 11, 1, 10, 0);
    drive(1, 0, 0, 0, 11, 1, 11, 0);
    drive(1, 0, 0, 0, 11, 1, 11, 1);
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    check_now("async_reset", {count, tc}, {4'd0, 1'b1, 1'b0, 1'b0, 1'b0} >> 0 & {4'd0, 1'b0, 2'b00} | {count == 4'd0 ? 7'd0 : {count, tc, 2'b00}});
    check_now("async_reset_count_tc", {count, tc, 2'b00}, {4'd0, 1'b0, 2'b00});
    // Reset held through an enabled edge: no step.
    drive(1, 0, 0, 0, 15, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    push_exp(0, 0, 15);
    drive(1, 0, 0, 0, 15, 0, 1, 0);
    drive(1, 0, 0, 0, 15, 0, 2, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
